complex_mult_stream: RTL and testbench
======================================

COMPLEX_MULT_STREAM -- requirements
Module: complex_mult_stream

Interface
REQ-001 SHALL have parameter D1_SIZE, default 13, signed width of data operand d1.
REQ-002 SHALL have parameter D2_SIZE, default 11, signed width of coefficient d2 (sign + 1 integer + D2_FRAC fraction bits).
REQ-003 SHALL have parameter D2_FRAC, default D2_SIZE-2, fraction bits of d2 discarded by rounding.
REQ-004 SHALL have ports: clk in 1, sole clock; rst in 1, reset (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have ports: di_vld in 1, input sample valid; di_rdy out 1, input accepted when di_vld&di_rdy.
REQ-006 SHALL have ports: d1_re, d1_im in D1_SIZE, two's-complement data; d2_re, d2_im in D2_SIZE, two's-complement coefficient.
REQ-007 SHALL have ports: conj in 1, multiply by conjugate of d2; rnd_mode in 2, rounding mode; both qualified by di_vld.
REQ-008 SHALL have ports: do_vld out 1; do_rdy in 1; do_re, do_im out D1_SIZE+1, result; do_sat out 1, result clipped.
REQ-009 SHALL have ports: sat_clr in 1, clears sat_cnt; sat_cnt out 16, count of saturated output samples.

Function
REQ-010 SHALL compute (d1_re + j d1_im)*(d2_re + j d2_im), or *(d2_re - j d2_im) when conj=1, at full precision before rounding.
REQ-011 SHALL carry conj and rnd_mode with each sample, so mode changes apply per sample, mid-stream included.
REQ-012 SHALL scale by 2^-D2_FRAC with rnd_mode 0 = round-half-to-even, 1 = round-half-away-from-zero, 2 = floor (truncate), 3 = treated as 0.
REQ-013 SHALL saturate each component symmetrically to +/-(2^D1_SIZE - 1); -2^D1_SIZE is never output.
REQ-014 SHALL assert do_sat with a sample if re or im clipped.
REQ-015 SHALL be a 2-stage pipeline (stage 1: products and sum; stage 2: round and saturate), latency 2 cycles from acceptance to do_vld with do_rdy held high.
REQ-016 SHALL give each stage its own valid bit; a stage loads when empty or when its content moves on in the same cycle (bubbles collapse).
REQ-017 SHALL drive di_rdy = ~rst & (stage-1 empty | stage-1 advancing); full throughput of 1 sample/cycle with do_rdy=1.
REQ-018 SHALL hold do_vld, do_re, do_im, do_sat stable while do_vld=1 and do_rdy=0; no sample lost, duplicated or reordered.
REQ-019 SHALL increment sat_cnt once per transferred sample (do_vld&do_rdy) with do_sat=1, stick at 16'hFFFF, and on sat_clr load 0; sat_clr wins over a simultaneous increment.
REQ-020 SHALL accept any d2 value; the |d2|<=1 restriction of the earlier multiplier does not apply.

Reset
REQ-021 SHALL, while rst=1, asynchronously clear all stage valids, do_vld, do_re, do_im, do_sat, sat_cnt to 0 and hold di_rdy=0.
REQ-022 SHALL discard in-flight samples on reset mid-operation; first output after release is the first sample accepted after release.

Structure
REQ-023 SHALL put rnd_mode encodings (RND_EVEN, RND_AWAY, RND_FLOOR) and latency constant CMULT_LAT=2 in shared package cmult_pkg.
REQ-024 SHALL implement round+saturate per component in sub-module cmult_round_sat, instantiated twice (re, im).

Verification (D1_SIZE=13, D2_SIZE=11, D2_FRAC=9; 1.0 = 512)
REQ-025 SHALL check d1=(100,-50), d2=(512,0), conj=0, do_rdy=1 -> do=(100,-50), do_sat=0, do_vld exactly 2 cycles after acceptance.
REQ-026 SHALL check d1=(100,0), d2=(0,512): conj=0 -> (0,100); conj=1 -> (0,-100), on back-to-back samples.
REQ-027 SHALL check d2=(256,0) with d1_re=3,1,-3: mode 0 -> 2,0,-2; mode 1 -> 2,1,-2; mode 2 -> 1,0,-2.
REQ-028 SHALL check d1=(4095,-4095), d2=(1023,1023) -> do_re=8191, do_sat=1, sat_cnt 0->1; then sat_clr with a saturated transfer in the same cycle -> sat_cnt=0.
REQ-029 SHALL check do_rdy=0 while 4 samples are offered -> 2 accepted, di_rdy=0, outputs held; do_rdy=1 -> all 4 delivered in order, no gaps.
REQ-030 SHALL check rst pulse with 2 samples in flight -> do_vld=0 at once, no stale output after release.

Source files
------------

// File: rtl/cmult_pkg.sv
// Shared constants for the streaming complex multiplier.
package cmult_pkg;

  typedef enum logic [1:0] {
    RND_EVEN  = 2'd0,
    RND_AWAY  = 2'd1,
    RND_FLOOR = 2'd2
  } rnd_mode_e;

  localparam int unsigned CMULT_LAT = 2;

endpackage

// File: rtl/cmult_round_sat.sv
// Scales one full-precision component by 2^-FRAC with the selected rounding,
// then clips symmetrically to +/-(2^(OUT_W-1) - 1).
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int unsigned IN_W  = 25,
  parameter int unsigned FRAC  = 9,
  parameter int unsigned OUT_W = 14
) (
  input  logic signed [IN_W-1:0]  val_i,
  input  logic [1:0]              mode_i,
  output logic signed [OUT_W-1:0] res_o,
  output logic                    sat_o
);

  // One guard bit so the round-up increment can never wrap.
  localparam int unsigned Q_W = IN_W - FRAC + 1;
  localparam logic [FRAC-1:0] HALF = FRAC'(1) << (FRAC - 1);
  localparam int QMAX_I = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [Q_W-1:0] QMAX = Q_W'(QMAX_I);
  localparam logic signed [Q_W-1:0] QMIN = -QMAX;

  logic signed [Q_W-1:0] q_floor;
  logic signed [Q_W-1:0] q_rnd;
  logic [FRAC-1:0]       frac;
  logic                  gt_half;
  logic                  eq_half;
  logic                  up;

  // Floor quotient plus a mode-dependent increment decided from the dropped bits.
  always_comb begin
    q_floor = {val_i[IN_W-1], val_i[IN_W-1:FRAC]};
    frac    = val_i[FRAC-1:0];
    gt_half = frac > HALF;
    eq_half = frac == HALF;
    unique case (mode_i)
      RND_FLOOR: up = 1'b0;
      // Floor already moved negatives away from zero on an exact half.
      RND_AWAY:  up = val_i[IN_W-1] ? gt_half : (gt_half | eq_half);
      default:   up = gt_half | (eq_half & q_floor[0]);
    endcase
    q_rnd = q_floor + $signed({{(Q_W-1){1'b0}}, up});
    sat_o = 1'b0;
    res_o = q_rnd[OUT_W-1:0];
    if (q_rnd > QMAX) begin
      sat_o = 1'b1;
      res_o = QMAX[OUT_W-1:0];
    end else if (q_rnd < QMIN) begin
      sat_o = 1'b1;
      res_o = QMIN[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/complex_mult_stream.sv
// Two-stage valid/ready complex multiplier: stage 1 forms the full-precision
// products and sums, stage 2 rounds, saturates and presents the result.
module complex_mult_stream
  import cmult_pkg::*;
#(
  parameter int unsigned D1_SIZE = 13,
  parameter int unsigned D2_SIZE = 11,
  parameter int unsigned D2_FRAC = D2_SIZE - 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      di_vld,
  output logic                      di_rdy,
  input  logic signed [D1_SIZE-1:0] d1_re,
  input  logic signed [D1_SIZE-1:0] d1_im,
  input  logic signed [D2_SIZE-1:0] d2_re,
  input  logic signed [D2_SIZE-1:0] d2_im,
  input  logic                      conj,
  input  logic [1:0]                rnd_mode,
  output logic                      do_vld,
  input  logic                      do_rdy,
  output logic signed [D1_SIZE:0]   do_re,
  output logic signed [D1_SIZE:0]   do_im,
  output logic                      do_sat,
  input  logic                      sat_clr,
  output logic [15:0]               sat_cnt
);

  localparam int unsigned P_W = D1_SIZE + D2_SIZE;
  localparam int unsigned S_W = P_W + 1;

  logic signed [P_W-1:0]   p_rr, p_ii, p_ri, p_ir;
  logic signed [S_W-1:0]   sum_re, sum_im;
  logic                    s1_vld_q;
  logic signed [S_W-1:0]   s1_re_q, s1_im_q;
  logic [1:0]              s1_mode_q;
  logic                    s2_vld_q;
  logic signed [D1_SIZE:0] s2_re_q, s2_im_q;
  logic                    s2_sat_q;
  logic signed [D1_SIZE:0] rs_re, rs_im;
  logic                    rs_re_sat, rs_im_sat;
  logic                    s1_free, s2_free;
  logic [15:0]             sat_cnt_q, sat_cnt_d;

  // Handshake: a stage may load when empty or when its content leaves this cycle.
  always_comb begin
    s2_free = ~s2_vld_q | do_rdy;
    s1_free = ~s1_vld_q | s2_free;
    di_rdy  = ~rst & s1_free;
  end

  // Full-precision products; conjugation folds into the sign of the d2_im terms.
  always_comb begin
    p_rr   = P_W'(d1_re) * P_W'(d2_re);
    p_ii   = P_W'(d1_im) * P_W'(d2_im);
    p_ri   = P_W'(d1_re) * P_W'(d2_im);
    p_ir   = P_W'(d1_im) * P_W'(d2_re);
    sum_re = conj ? S_W'(p_rr) + S_W'(p_ii) : S_W'(p_rr) - S_W'(p_ii);
    sum_im = conj ? S_W'(p_ir) - S_W'(p_ri) : S_W'(p_ri) + S_W'(p_ir);
  end

  // Stage 1 register: sums plus the per-sample rounding mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_mode_q <= '0;
    end else if (s1_free) begin
      s1_vld_q <= di_vld;
      if (di_vld) begin
        s1_re_q   <= sum_re;
        s1_im_q   <= sum_im;
        s1_mode_q <= rnd_mode;
      end
    end
  end

  cmult_round_sat #(.IN_W(S_W), .FRAC(D2_FRAC), .OUT_W(D1_SIZE + 1)) u_rs_re (
    .val_i (s1_re_q),
    .mode_i(s1_mode_q),
    .res_o (rs_re),
    .sat_o (rs_re_sat)
  );

  cmult_round_sat #(.IN_W(S_W), .FRAC(D2_FRAC), .OUT_W(D1_SIZE + 1)) u_rs_im (
    .val_i (s1_im_q),
    .mode_i(s1_mode_q),
    .res_o (rs_im),
    .sat_o (rs_im_sat)
  );

  // Stage 2 register: holds the output while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      s2_re_q  <= '0;
      s2_im_q  <= '0;
      s2_sat_q <= 1'b0;
    end else if (s2_free) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_re_q  <= rs_re;
        s2_im_q  <= rs_im;
        s2_sat_q <= rs_re_sat | rs_im_sat;
      end
    end
  end

  // Saturation counter next state: clear dominates, count sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = '0;
    else if (s2_vld_q && do_rdy && s2_sat_q && sat_cnt_q != '1)
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  // Saturation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign do_vld  = s2_vld_q;
  assign do_re   = s2_re_q;
  assign do_im   = s2_im_q;
  assign do_sat  = s2_sat_q;
  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_complex_mult_stream.sv
// Self-checking bench for complex_mult_stream with default parameters (1.0 = 512).
module tb_complex_mult_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               di_vld, di_rdy;
  logic signed [12:0] d1_re, d1_im;
  logic signed [10:0] d2_re, d2_im;
  logic               conj;
  logic [1:0]         rnd_mode;
  logic               do_vld, do_rdy;
  logic signed [13:0] do_re, do_im;
  logic               do_sat;
  logic               sat_clr;
  logic [15:0]        sat_cnt;

  always #5 clk = ~clk;

  complex_mult_stream #(.D1_SIZE(13), .D2_SIZE(11), .D2_FRAC(9)) dut (
    .clk(clk), .rst(rst), .di_vld(di_vld), .di_rdy(di_rdy),
    .d1_re(d1_re), .d1_im(d1_im), .d2_re(d2_re), .d2_im(d2_im),
    .conj(conj), .rnd_mode(rnd_mode), .do_vld(do_vld), .do_rdy(do_rdy),
    .do_re(do_re), .do_im(do_im), .do_sat(do_sat),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  typedef struct {
    longint re;
    longint im;
    bit     sat;
  } res_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  res_t   exp_q[$];
  longint log_re[$];
  longint log_im[$];
  bit     log_sat[$];
  longint m_sat = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scale by 1/512 under the given rounding mode, in sign/magnitude terms.
  function automatic longint scale(input longint v, input int md);
    longint m, qm, r;
    if (md == 2) return (v >= 0) ? v / 512 : -((-v + 511) / 512);
    m = (v < 0) ? -v : v;
    if (md == 1) begin
      qm = (m + 256) / 512;
    end else begin
      qm = m / 512;
      r  = m % 512;
      if (r > 256 || (r == 256 && (qm % 2) == 1)) qm++;
    end
    return (v < 0) ? -qm : qm;
  endfunction

  function automatic res_t model(input longint ar, ai, br, bi, input bit cj, input int md);
    res_t   r;
    longint vr, vi, qr, qi;
    vr = cj ? ar * br + ai * bi : ar * br - ai * bi;
    vi = cj ? ai * br - ar * bi : ar * bi + ai * br;
    qr = scale(vr, md);
    qi = scale(vi, md);
    r.sat = (qr > 8191) || (qr < -8191) || (qi > 8191) || (qi < -8191);
    r.re  = (qr > 8191) ? 8191 : (qr < -8191) ? -8191 : qr;
    r.im  = (qi > 8191) ? 8191 : (qi < -8191) ? -8191 : qi;
    return r;
  endfunction

  // Compare process: inputs change just after posedge, so negedge values hold through the next edge.
  always @(negedge clk) begin
    res_t e;
    bit   xfer_sat;
    if (rst) begin
      exp_q.delete();
      m_sat = 0;
      chk("rst_do_vld", do_vld, 0);
      chk("rst_di_rdy", di_rdy, 0);
      chk("rst_sat_cnt", sat_cnt, 0);
    end else begin
      chk("sat_cnt", sat_cnt, m_sat);
      xfer_sat = 1'b0;
      if (do_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", do_vld, 0);
        end else begin
          e = exp_q[0];
          chk("do_re", do_re, e.re);
          chk("do_im", do_im, e.im);
          chk("do_sat", do_sat, e.sat);
          if (do_rdy) begin
            log_re.push_back(do_re);
            log_im.push_back(do_im);
            log_sat.push_back(do_sat);
            void'(exp_q.pop_front());
            xfer_sat = e.sat;
          end
        end
      end
      if (sat_clr) m_sat = 0;
      else if (xfer_sat && m_sat != 65535) m_sat++;
      if (di_vld && di_rdy)
        exp_q.push_back(model(d1_re, d1_im, d2_re, d2_im, conj, rnd_mode));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int ar, ai, br, bi, input bit cj, input int md);
    d1_re = 13'(ar); d1_im = 13'(ai);
    d2_re = 11'(br); d2_im = 11'(bi);
    conj = cj; rnd_mode = 2'(md);
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input int ar, ai, br, bi, input bit cj, input int md);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    set_in(ar, ai, br, bi, cj, md);
    di_vld = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = di_rdy;
      n++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", di_rdy, 1);
    di_vld = 1'b0;
  endtask

  task automatic chk_log(input string name, input int idx, input longint re, im, input bit sat);
    if (idx >= log_re.size()) begin
      chk({name, "_missing"}, log_re.size(), idx + 1);
    end else begin
      chk({name, "_re"}, log_re[idx], re);
      chk({name, "_im"}, log_im[idx], im);
      chk({name, "_sat"}, log_sat[idx], sat);
    end
  endtask

  initial begin
    int base, k, n;
    bit acc;
    int t27_in[3]     = '{3, 1, -3};
    int t27_exp[3][3] = '{'{2, 0, -2}, '{2, 1, -2}, '{1, 0, -2}};
    int t29_in[4]     = '{10, 20, 30, 40};

    rst = 1'b1; di_vld = 1'b0; do_rdy = 1'b0; sat_clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    step(3);
    chk("reset_do_re", do_re, 0);
    chk("reset_do_im", do_im, 0);
    chk("reset_do_sat", do_sat, 0);
    rst = 1'b0;
    do_rdy = 1'b1;
    step(2);

    // Identity coefficient, two-register latency.
    base = log_re.size();
    set_in(100, -50, 512, 0, 0, 0);
    di_vld = 1'b1;
    @(negedge clk);
    chk("t025_di_rdy", di_rdy, 1);
    @(posedge clk); #1;
    di_vld = 1'b0;
    chk("t025_vld_early", do_vld, 0);
    step(1);
    chk("t025_vld", do_vld, 1);
    chk("t025_re_lit", do_re, 100);
    chk("t025_im_lit", do_im, -50);
    chk("t025_sat_lit", do_sat, 0);
    step(2);
    chk_log("t025", base, 100, -50, 0);

    // Multiply by j, then by conjugate of j, back to back.
    base = log_re.size();
    send(100, 0, 0, 512, 0, 0);
    send(100, 0, 0, 512, 1, 0);
    step(4);
    chk_log("t026_a", base, 0, 100, 0);
    chk_log("t026_b", base + 1, 0, -100, 0);

    // Rounding modes at exact halves, mode switching per sample.
    base = log_re.size();
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 3; i++)
        send(t27_in[i], 0, 256, 0, 0, m);
    send(3, 0, 256, 0, 0, 3);
    send(-3, 0, 256, 0, 0, 3);
    step(4);
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 3; i++)
        chk_log($sformatf("t027_m%0d_%0d", m, i), base + m * 3 + i, t27_exp[m][i], 0, 0);
    chk_log("t027_m3_pos", base + 9, 2, 0, 0);
    chk_log("t027_m3_neg", base + 10, -2, 0, 0);

    // Saturation and counter, then clear colliding with a saturated transfer.
    base = log_re.size();
    chk("t028_cnt0", sat_cnt, 0);
    send(4095, -4095, 1023, 1023, 0, 0);
    step(3);
    chk_log("t028_sat", base, 8191, 0, 1);
    chk("t028_cnt1", sat_cnt, 1);
    do_rdy = 1'b0;
    send(4095, -4095, 1023, 1023, 0, 0);
    step(1);
    chk("t028_held_vld", do_vld, 1);
    chk("t028_held_sat", do_sat, 1);
    do_rdy = 1'b1; sat_clr = 1'b1;
    step(1);
    sat_clr = 1'b0;
    chk("t028_clr_wins", sat_cnt, 0);
    step(2);

    // Backpressure: only two samples fit, then drain with no gaps.
    base = log_re.size();
    do_rdy = 1'b0;
    k = 0;
    set_in(t29_in[0], 0, 512, 0, 0, 0);
    di_vld = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = di_rdy;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        set_in(t29_in[k], 0, 512, 0, 0, 0);
      end
    end
    chk("t029_accepted", k, 2);
    chk("t029_di_rdy", di_rdy, 0);
    chk("t029_held_vld", do_vld, 1);
    chk("t029_held_re", do_re, 10);
    do_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t029_nogap", do_vld, 1);
      acc = di_vld && di_rdy;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 4) set_in(t29_in[k], 0, 512, 0, 0, 0);
        else di_vld = 1'b0;
      end
    end
    di_vld = 1'b0;
    chk("t029_all_sent", k, 4);
    step(2);
    for (int i = 0; i < 4; i++)
      chk_log($sformatf("t029_%0d", i), base + i, t29_in[i], 0, 0);

    // Reset with two samples in flight.
    send(300, 0, 512, 0, 0, 0);
    send(400, 0, 512, 0, 0, 0);
    base = log_re.size();
    rst = 1'b1;
    #1;
    chk("t030_vld_async", do_vld, 0);
    chk("t030_rdy_async", di_rdy, 0);
    step(2);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (do_vld) n++;
    end
    chk("t030_no_stale", n, 0);
    @(posedge clk); #1;
    send(7, 0, 512, 0, 0, 0);
    step(3);
    chk("t030_count", log_re.size(), base + 1);
    chk_log("t030_first", base, 7, 0, 0);
    chk("t030_empty_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
